// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single data memory. Port 0 is the CPU control
// unit and port 1 is the loader/debug port. Each granted access runs through
// the four-state sequence IDLE -> ADDR -> XFER -> DONE, one clock per state.
//
// Every state's action is registered on the clock edge that leaves it:
//   IDLE edge : pick a winner, latch its cmd/addr/wdata, raise its gnt
//   ADDR edge : drive addr_memory/cmd_memory (and data_memory on a write)
//   XFER edge : capture data_memory into rdata on a read
//   DONE edge : pulse done, release the bus, cmd_memory back to read
// This means a request sampled at edge 0 shows done in the cycle after edge 3.
// Each gnt stays high for four cycles, and back-to-back transactions run at
// one per four cycles.
//
// Request handshake: reqN is a level. The requester holds reqN, cmdN, addrN
// and wdataN until it sees doneN high. cmd/addr/wdata are captured at the
// grant edge, so later changes (including dropping reqN) do not affect an
// access already in flight. A reqN still high in the done cycle is eligible
// again at the very next IDLE edge.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : on contention the port not granted last
//                                   wins. After reset, port 0 wins first.
//                       undefined : fixed priority, port 0 wins on contention.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   req0/req1     level access requests
//   cmd0/cmd1     8'h01 write, anything else read
//   addr0/addr1   access address (AW bits)
//   wdata0/wdata1 write data (DW bits)
//   gnt0/gnt1     grant, high from grant cycle through done cycle
//   done0/done1   one-cycle completion pulse
//   rdata         last read data, valid from the done cycle on
//   cmd_memory    command to memory (8'h00 read, 8'h01 write)
//   addr_memory   address to memory, holds its last value while idle
//   data_memory   bidirectional memory data bus, driven only on writes
//   fsm_state     current FSM state (0 IDLE, 1 ADDR, 2 XFER, 3 DONE)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [7:0]    cmd0,
   input  logic [7:0]    cmd1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          done0,
   output logic          done1,
   output logic [DW-1:0] rdata,
   output logic [7:0]    cmd_memory,
   output logic [AW-1:0] addr_memory,
   inout  wire  [DW-1:0] data_memory,
   output logic [1:0]    fsm_state
);

   localparam logic [7:0] CMD_READ  = 8'h00;
   localparam logic [7:0] CMD_WRITE = 8'h01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_d;

   // Transaction captured at the grant edge. lat_port: 0 = port 0, 1 = port 1.
   logic          lat_port, lat_port_d;
   logic          lat_wr,   lat_wr_d;
   logic [AW-1:0] lat_addr, lat_addr_d;
   logic [DW-1:0] lat_wdata, lat_wdata_d;

   logic          bus_oe, bus_oe_d;
   logic          gnt0_d, gnt1_d, done0_d, done1_d;
   logic [DW-1:0] rdata_d;
   logic [7:0]    cmd_d;
   logic [AW-1:0] addr_d;

   logic          win_port;

`ifdef ARB_ROUND_ROBIN_EN
   // Port granted most recently. Reset value 1 lets port 0 win the first tie.
   logic          last_port, last_port_d;
`endif

   assign fsm_state   = state;
   assign data_memory = bus_oe ? lat_wdata : {DW{1'bz}};

   // Arbitration: win_port is meaningful only when at least one request is up.
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      if (req0 && req1) win_port = ~last_port;
      else              win_port = ~req0;
`else
      win_port = ~req0;
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (req0 || req1) state_d = ADDR;
         ADDR:    state_d = XFER;
         XFER:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: next values for the registered outputs and latches
   always_comb begin
      gnt0_d      = gnt0;
      gnt1_d      = gnt1;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      rdata_d     = rdata;
      cmd_d       = cmd_memory;
      addr_d      = addr_memory;
      bus_oe_d    = bus_oe;
      lat_port_d  = lat_port;
      lat_wr_d    = lat_wr;
      lat_addr_d  = lat_addr;
      lat_wdata_d = lat_wdata;
`ifdef ARB_ROUND_ROBIN_EN
      last_port_d = last_port;
`endif
      case (state)
         IDLE: begin
            gnt0_d = 1'b0;
            gnt1_d = 1'b0;
            if (req0 || req1) begin
               gnt0_d      = ~win_port;
               gnt1_d      = win_port;
               lat_port_d  = win_port;
               // Any command other than 8'h01 is handled as a read.
               lat_wr_d    = win_port ? (cmd1 == CMD_WRITE) : (cmd0 == CMD_WRITE);
               lat_addr_d  = win_port ? addr1  : addr0;
               lat_wdata_d = win_port ? wdata1 : wdata0;
            end
         end
         ADDR: begin
            addr_d   = lat_addr;
            cmd_d    = lat_wr ? CMD_WRITE : CMD_READ;
            bus_oe_d = lat_wr;
         end
         XFER: begin
            if (!lat_wr) rdata_d = data_memory;
         end
         DONE: begin
            done0_d  = ~lat_port;
            done1_d  = lat_port;
            bus_oe_d = 1'b0;
            cmd_d    = CMD_READ;
`ifdef ARB_ROUND_ROBIN_EN
            last_port_d = lat_port;
`endif
         end
         default: begin
            bus_oe_d = 1'b0;
         end
      endcase
   end

   // Output and latch registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         rdata       <= '0;
         cmd_memory  <= CMD_READ;
         addr_memory <= '0;
         bus_oe      <= 1'b0;
         lat_port    <= 1'b0;
         lat_wr      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_port   <= 1'b1;
`endif
      end else begin
         gnt0        <= gnt0_d;
         gnt1        <= gnt1_d;
         done0       <= done0_d;
         done1       <= done1_d;
         rdata       <= rdata_d;
         cmd_memory  <= cmd_d;
         addr_memory <= addr_d;
         bus_oe      <= bus_oe_d;
         lat_port    <= lat_port_d;
         lat_wr      <= lat_wr_d;
         lat_addr    <= lat_addr_d;
         lat_wdata   <= lat_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_port   <= last_port_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a small behavioural memory on the
// data_memory bus. Expected values are written out by hand per step.
// Outputs are sampled 1 ns after the rising edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic       clk;
   logic       rst;
   logic       req0, req1;
   logic [7:0] cmd0, cmd1;
   logic [7:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, done0, done1;
   logic [7:0] rdata;
   logic [7:0] cmd_memory;
   logic [7:0] addr_memory;
   wire  [7:0] data_memory;
   logic [1:0] fsm_state;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   mem_arbiter #(.DW(8), .AW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0        (req0),
      .req1        (req1),
      .cmd0        (cmd0),
      .cmd1        (cmd1),
      .addr0       (addr0),
      .addr1       (addr1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .gnt0        (gnt0),
      .gnt1        (gnt1),
      .done0       (done0),
      .done1       (done1),
      .rdata       (rdata),
      .cmd_memory  (cmd_memory),
      .addr_memory (addr_memory),
      .data_memory (data_memory),
      .fsm_state   (fsm_state)
   );

   // ---------------- memory model ----------------
   // Drives the bus only while a read access owns it.
   logic [7:0] mem [0:255];
   logic       mem_drive;
   logic [7:0] mem_rd;

   assign mem_drive   = (gnt0 || gnt1) && (cmd_memory == 8'h00);
   assign mem_rd      = mem[addr_memory];
   assign data_memory = mem_drive ? mem_rd : 8'hzz;

   always @(posedge clk) begin
      if (cmd_memory == 8'h01) mem[addr_memory] <= data_memory;
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Contention winners, bit k = port granted in round k.
   logic [3:0] exp_win;

   // ---------------- stimulus ----------------
   initial begin
`ifdef ARB_ROUND_ROBIN_EN
      // Last grant before the contention run is port 0, so port 1 starts.
      exp_win = 4'b0101;
`else
      exp_win = 4'b0000;
`endif
      rst = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      cmd0 = 8'h00; cmd1 = 8'h00;
      addr0 = 8'h00; addr1 = 8'h00;
      wdata0 = 8'h00; wdata1 = 8'h00;
      #1;
      check("rst_state", fsm_state, 0);
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_done0", done0, 0);
      check("rst_done1", done1, 0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_cmd", cmd_memory, 8'h00);
      check("rst_addr", addr_memory, 8'h00);
      tick();
      tick();
      rst = 1'b1;

      // ---- port 0 write A5 -> 0x10 ----
      req0 = 1'b1; cmd0 = 8'h01; addr0 = 8'h10; wdata0 = 8'hA5;
      tick(); // grant edge
      check("w0_gnt0", gnt0, 1);
      check("w0_gnt1", gnt1, 0);
      check("w0_state", fsm_state, 1);
      tick();
      check("w0_cmd", cmd_memory, 8'h01);
      check("w0_addr", addr_memory, 8'h10);
      check("w0_bus1", data_memory, 8'hA5);
      tick();
      check("w0_bus2", data_memory, 8'hA5);
      check("w0_early_done", done0, 0);
      tick();
      check("w0_done0", done0, 1);
      check("w0_gnt0_done", gnt0, 1);
      check("w0_cmd_idle", cmd_memory, 8'h00);
      req0 = 1'b0;
      tick();
      check("w0_gnt0_off", gnt0, 0);
      check("w0_done0_off", done0, 0);
      check("w0_state_idle", fsm_state, 0);

      // ---- port 0 read 0x10 ----
      req0 = 1'b1; cmd0 = 8'h00; addr0 = 8'h10;
      tick();
      check("r0_gnt0", gnt0, 1);
      tick();
      check("r0_addr", addr_memory, 8'h10);
      check("r0_cmd", cmd_memory, 8'h00);
      tick();
      check("r0_rdata_xfer", rdata, 8'hA5);
      check("r0_early_done", done0, 0);
      tick();
      check("r0_done0", done0, 1);
      check("r0_rdata", rdata, 8'hA5);
      req0 = 1'b0;
      tick();
      check("r0_gnt0_off", gnt0, 0);

      // ---- port 1 write 3C -> 0x20 ----
      req1 = 1'b1; cmd1 = 8'h01; addr1 = 8'h20; wdata1 = 8'h3C;
      tick();
      check("w1_gnt1", gnt1, 1);
      check("w1_gnt0", gnt0, 0);
      tick();
      check("w1_bus1", data_memory, 8'h3C);
      check("w1_addr", addr_memory, 8'h20);
      tick();
      check("w1_bus2", data_memory, 8'h3C);
      tick();
      check("w1_done1", done1, 1);
      check("w1_done0", done0, 0);
      req1 = 1'b0;
      tick();
      check("w1_gnt1_off", gnt1, 0);

      // ---- port 1 read 0x20 with an undefined command (treated as read) ----
      req1 = 1'b1; cmd1 = 8'h7F; addr1 = 8'h20;
      tick();
      check("r1_gnt1", gnt1, 1);
      tick();
      check("r1_cmd_read", cmd_memory, 8'h00);
      tick();
      tick();
      check("r1_done1", done1, 1);
      check("r1_rdata", rdata, 8'h3C);
      req1 = 1'b0;
      tick();

      // ---- inputs change after grant: read must use 0x10 ----
      req0 = 1'b1; cmd0 = 8'h00; addr0 = 8'h10;
      tick();
      check("nc_gnt0", gnt0, 1);
      addr0 = 8'h55; req0 = 1'b0; cmd0 = 8'h01;
      tick();
      check("nc_addr", addr_memory, 8'h10);
      check("nc_cmd", cmd_memory, 8'h00);
      tick();
      tick();
      check("nc_done0", done0, 1);
      check("nc_rdata", rdata, 8'hA5);
      tick();
      check("nc_gnt0_off", gnt0, 0);
      check("nc_idle", fsm_state, 0);

      // ---- contention: both ports read continuously ----
      req0 = 1'b1; cmd0 = 8'h00; addr0 = 8'h10;
      req1 = 1'b1; cmd1 = 8'h00; addr1 = 8'h20;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("ct_gnt0", gnt0, {31'd0, ~exp_win[k]});
         check("ct_gnt1", gnt1, {31'd0, exp_win[k]});
         tick();
         tick();
         tick();
         check("ct_done0", done0, {31'd0, ~exp_win[k]});
         check("ct_done1", done1, {31'd0, exp_win[k]});
         check("ct_rdata", rdata, exp_win[k] ? 32'h3C : 32'hA5);
         if (k == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      tick();
      check("ct_gnt0_off", gnt0, 0);
      check("ct_gnt1_off", gnt1, 0);

      // ---- reset during XFER of a read, req1 pending ----
      req0 = 1'b1; cmd0 = 8'h00; addr0 = 8'h10;
      tick();
      check("ra_gnt0", gnt0, 1);
      tick();
      check("ra_xfer", fsm_state, 2);
      #2;
      rst = 1'b0;
      req0 = 1'b0;
      req1 = 1'b1; cmd1 = 8'h00; addr1 = 8'h20;
      #1;
      check("ra_state", fsm_state, 0);
      check("ra_gnt0", gnt0, 0);
      check("ra_done0", done0, 0);
      check("ra_rdata", rdata, 8'h00);
      check("ra_cmd", cmd_memory, 8'h00);
      check("ra_addr", addr_memory, 8'h00);
      tick();
      check("ra_hold_done0", done0, 0);
      check("ra_hold_gnt1", gnt1, 0);
      #2;
      rst = 1'b1;
      tick();
      check("ra_first_gnt1", gnt1, 1);
      check("ra_first_state", fsm_state, 1);
      tick();
      tick();
      tick();
      check("ra_done1", done1, 1);
      check("ra_rdata_after", rdata, 8'h3C);
      req1 = 1'b0;
      tick();
      check("ra_gnt1_off", gnt1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
